// File: rtl/conv_window_sequencer.sv
// Convolution window sequencer: buffers one kernel and one patch from serial
// valid/ready streams, drives an external SIZE-lane Hadamard product unit,
// captures its products and reduces them with a sequential accumulator.
// The result leaves on a valid/ready stream. All arithmetic is unsigned and
// wraps modulo 2^WIDTH.
module conv_window_sequencer #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  k_valid,
  input  logic [WIDTH-1:0]      k_data,
  output logic                  k_ready,
  input  logic                  p_valid,
  input  logic [WIDTH-1:0]      p_data,
  output logic                  p_ready,
  output logic [SIZE*WIDTH-1:0] hp_kernel,
  output logic [SIZE*WIDTH-1:0] hp_patch,
  input  logic [SIZE*WIDTH-1:0] hp_res,
  output logic                  o_valid,
  output logic [WIDTH-1:0]      o_data,
  input  logic                  o_ready,
  output logic                  kernel_loaded,
  output logic                  busy
);

  localparam int CW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);
  // Counter value after the first kernel word; with a single lane the load
  // is already complete and the counter goes back to zero.
  localparam logic [CW-1:0] K_FIRST_NEXT = (SIZE == 1) ? '0 : CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_K,
    LOAD_P,
    MUL,
    SUM,
    OUT
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] kbuf [SIZE];
  logic [WIDTH-1:0] pbuf [SIZE];
  logic [WIDTH-1:0] prod [SIZE];
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic             k_acc;
  logic             p_acc;

  // Unsigned modulo-2^WIDTH addition used by the reduction.
  function automatic logic [WIDTH-1:0] add_wrap(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return a + b;
  endfunction

  assign k_acc  = k_valid && k_ready;
  assign p_acc  = p_valid && p_ready;
  assign acc_nx = add_wrap(acc, prod[cnt]);

  // Buffers drive the Hadamard unit directly, one WIDTH slice per lane.
  for (genvar g = 0; g < SIZE; g++) begin : g_lane
    assign hp_kernel[g*WIDTH +: WIDTH] = kbuf[g];
    assign hp_patch[g*WIDTH +: WIDTH]  = pbuf[g];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, stream ready signals and busy; a kernel word pre-empts a
  // patch word while no patch is in progress.
  always_comb begin
    state_nx = state;
    k_ready  = 1'b0;
    p_ready  = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE: begin
        k_ready = 1'b1;
        busy    = 1'b0;
        if (k_valid) state_nx = (SIZE == 1) ? LOAD_P : LOAD_K;
      end
      LOAD_K: begin
        k_ready = 1'b1;
        if (k_valid && cnt == LAST) state_nx = LOAD_P;
      end
      LOAD_P: begin
        if (cnt == '0) begin
          k_ready = 1'b1;
          p_ready = !k_valid;
          busy    = 1'b0;
          if (k_valid)                state_nx = (SIZE == 1) ? LOAD_P : LOAD_K;
          else if (p_valid && cnt == LAST) state_nx = MUL;
        end else begin
          p_ready = 1'b1;
          if (p_valid && cnt == LAST) state_nx = MUL;
        end
      end
      MUL: state_nx = SUM;
      SUM: if (cnt == LAST) state_nx = OUT;
      OUT: if (o_ready) state_nx = LOAD_P;
      default: state_nx = IDLE;
    endcase
  end

  // Word counter, buffers, product capture, accumulator and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      kernel_loaded <= 1'b0;
      o_valid       <= 1'b0;
      o_data        <= '0;
      acc           <= '0;
      for (int i = 0; i < SIZE; i++) begin
        kbuf[i] <= '0;
        pbuf[i] <= '0;
        prod[i] <= '0;
      end
    end else begin
      case (state)
        // load stage: serial words into lane buffers
        IDLE, LOAD_P: begin
          if (k_acc) begin
            kbuf[0]       <= k_data;
            cnt           <= K_FIRST_NEXT;
            kernel_loaded <= (SIZE == 1);
          end else if (p_acc) begin
            pbuf[cnt] <= p_data;
            cnt       <= (cnt == LAST) ? '0 : cnt + CW'(1);
          end
        end
        LOAD_K: begin
          if (k_acc) begin
            kbuf[cnt] <= k_data;
            if (cnt == LAST) begin
              cnt           <= '0;
              kernel_loaded <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        // product capture stage
        MUL: begin
          for (int i = 0; i < SIZE; i++) prod[i] <= hp_res[i*WIDTH +: WIDTH];
          acc <= '0;
          cnt <= '0;
        end
        // reduction stage: one lane per cycle
        SUM: begin
          acc <= acc_nx;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            o_data  <= acc_nx;
            o_valid <= 1'b1;
          end
        end
        // output stage: hold until consumed
        OUT: begin
          if (o_ready) begin
            o_valid <= 1'b0;
            cnt     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Testbench for conv_window_sequencer: models the external Hadamard unit,
// drives kernel/patch streams and compares results against a dot-product
// reference computed directly from the buffered words.
module tb_conv_window_sequencer;

  localparam int W = 32;
  localparam int S = 9;

  logic           clk = 1'b0;
  logic           rst;
  logic           k_valid, p_valid, o_ready;
  logic [W-1:0]   k_data, p_data;
  logic           k_ready, p_ready, o_valid, kernel_loaded, busy;
  logic [W-1:0]   o_data;
  logic [S*W-1:0] hp_kernel, hp_patch, hp_res;

  int vectors = 0;
  int miscompares = 0;
  bit timed_out = 1'b0;

  logic [W-1:0] kern [S];
  logic [W-1:0] pat  [S];

  conv_window_sequencer #(.WIDTH(W), .SIZE(S)) dut (
    .clk(clk), .rst(rst),
    .k_valid(k_valid), .k_data(k_data), .k_ready(k_ready),
    .p_valid(p_valid), .p_data(p_data), .p_ready(p_ready),
    .hp_kernel(hp_kernel), .hp_patch(hp_patch), .hp_res(hp_res),
    .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready),
    .kernel_loaded(kernel_loaded), .busy(busy)
  );

  always #5 clk = ~clk;

  // External Hadamard unit: lane-wise products, low W bits.
  always_comb begin
    hp_res = '0;
    for (int i = 0; i < S; i++)
      hp_res[i*W +: W] = hp_kernel[i*W +: W] * hp_patch[i*W +: W];
  end

  // Reference: dot product of kernel and patch, modulo 2^W.
  function automatic logic [W-1:0] model_dot();
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < S; i++) s = s + ({32'b0, kern[i]} * {32'b0, pat[i]});
    return s[W-1:0];
  endfunction

  function automatic logic [S*W-1:0] pack_kern();
    logic [S*W-1:0] v;
    for (int i = 0; i < S; i++) v[i*W +: W] = kern[i];
    return v;
  endfunction

  task automatic drive_k(input logic [W-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    k_valid = 1'b1;
    k_data  = d;
    forever begin
      #1;
      if (k_ready) begin @(posedge clk); break; end
      @(negedge clk);
      n++;
      if (n > 200) begin timed_out = 1'b1; break; end
    end
    #1 k_valid = 1'b0;
  endtask

  task automatic drive_p(input logic [W-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    p_valid = 1'b1;
    p_data  = d;
    forever begin
      #1;
      if (p_ready) begin @(posedge clk); break; end
      @(negedge clk);
      n++;
      if (n > 200) begin timed_out = 1'b1; break; end
    end
    #1 p_valid = 1'b0;
  endtask

  task automatic load_kernel(input int from, input int maxgap);
    for (int i = from; i < S; i++) begin
      drive_k(kern[i]);
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(posedge clk);
    end
  endtask

  // gap>0 and rnd=0 inserts gap idle cycles after words 3 and 6.
  task automatic load_patch(input int gap, input bit rnd);
    for (int i = 0; i < S; i++) begin
      drive_p(pat[i]);
      if (rnd && gap > 0)                 repeat ($urandom_range(0, gap)) @(posedge clk);
      else if (!rnd && (i == 3 || i == 6)) repeat (gap) @(posedge clk);
    end
  endtask

  // Counts edges after the last accepted patch word until o_valid is seen.
  task automatic wait_result(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!o_valid && n < 100);
  endtask

  task automatic consume();
    @(negedge clk);
    o_ready = 1'b1;
    @(posedge clk);
    #1 o_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; k_valid = 1'b0; p_valid = 1'b0; o_ready = 1'b0;
    k_data = '0; p_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    vectors++; if (k_ready !== 1'b1) begin miscompares++; $display("FAIL reset_k_ready got %b want 1", k_ready); end
    vectors++; if (p_ready !== 1'b0) begin miscompares++; $display("FAIL reset_p_ready got %b want 0", p_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_o_valid got %b want 0", o_valid); end
    vectors++; if (o_data !== '0) begin miscompares++; $display("FAIL reset_o_data got %h want 0", o_data); end
    vectors++; if (kernel_loaded !== 1'b0) begin miscompares++; $display("FAIL reset_kernel_loaded got %b want 0", kernel_loaded); end
    vectors++; if (hp_kernel !== '0 || hp_patch !== '0) begin miscompares++; $display("FAIL reset_buffers kernel %h patch %h want 0", hp_kernel, hp_patch); end
  endtask

  task automatic test_no_kernel();
    p_valid = 1'b1;
    p_data  = 32'd5;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      vectors++; if (p_ready !== 1'b0 || o_valid !== 1'b0) begin miscompares++; $display("FAIL no_kernel cycle %0d p_ready %b o_valid %b want 0 0", c, p_ready, o_valid); end
    end
    p_valid = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    logic [W-1:0] exp;
    for (int i = 0; i < S; i++) begin kern[i] = 32'd1; pat[i] = 32'(i + 1); end
    load_kernel(0, 0);
    vectors++; if (kernel_loaded !== 1'b1) begin miscompares++; $display("FAIL basic_kernel_loaded got %b want 1", kernel_loaded); end
    vectors++; if (hp_kernel !== pack_kern()) begin miscompares++; $display("FAIL basic_hp_kernel got %h want %h", hp_kernel, pack_kern()); end
    load_patch(0, 1'b0);
    exp = model_dot();
    wait_result(n);
    vectors++; if (n !== 10) begin miscompares++; $display("FAIL basic_latency got %0d edges want 10", n); end
    vectors++; if (o_data !== exp || exp !== 32'd45) begin miscompares++; $display("FAIL basic_sum got %0d want %0d (45)", o_data, exp); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_out got %b want 1", busy); end
    consume();
    vectors++; if (o_valid !== 1'b0 || p_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL basic_after_consume o_valid %b p_ready %b busy %b want 0 1 0", o_valid, p_ready, busy); end
    vectors++; if (timed_out) begin miscompares++; $display("FAIL basic_timeout got 1 want 0"); timed_out = 1'b0; end
  endtask

  task automatic test_wrap();
    int n;
    logic [W-1:0] exp;
    for (int i = 0; i < S; i++) begin kern[i] = 32'hFFFF_FFFF; pat[i] = 32'd1; end
    drive_k(kern[0]);
    vectors++; if (kernel_loaded !== 1'b0) begin miscompares++; $display("FAIL wrap_reload_invalidates got %b want 0", kernel_loaded); end
    load_kernel(1, 0);
    load_patch(0, 1'b0);
    exp = model_dot();
    wait_result(n);
    vectors++; if (o_data !== exp || exp !== 32'hFFFF_FFF7) begin miscompares++; $display("FAIL wrap_sum got %h want %h (fffffff7)", o_data, exp); end
    consume();
    vectors++; if (timed_out) begin miscompares++; $display("FAIL wrap_timeout got 1 want 0"); timed_out = 1'b0; end
  endtask

  task automatic test_backpressure();
    int n;
    logic [W-1:0] exp;
    for (int i = 0; i < S; i++) pat[i] = $urandom;
    load_patch(0, 1'b0);
    exp = model_dot();
    wait_result(n);
    @(negedge clk);
    k_valid = 1'b1; k_data = 32'd3; p_valid = 1'b1; p_data = 32'd4;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++; if (o_valid !== 1'b1 || o_data !== exp || k_ready !== 1'b0 || p_ready !== 1'b0) begin
        miscompares++; $display("FAIL backpressure cycle %0d o_valid %b o_data %h k_ready %b p_ready %b want 1 %h 0 0", c, o_valid, o_data, k_ready, p_ready, exp);
      end
      @(negedge clk);
    end
    k_valid = 1'b0; p_valid = 1'b0;
    o_ready = 1'b1;
    @(posedge clk);
    #1 o_ready = 1'b0;
    vectors++; if (o_valid !== 1'b0 || p_ready !== 1'b1) begin miscompares++; $display("FAIL backpressure_release o_valid %b p_ready %b want 0 1", o_valid, p_ready); end
    vectors++; if (timed_out) begin miscompares++; $display("FAIL backpressure_timeout got 1 want 0"); timed_out = 1'b0; end
  endtask

  task automatic test_kernel_priority();
    int n;
    logic [W-1:0] exp;
    for (int i = 0; i < S; i++) begin kern[i] = 32'd2; pat[i] = 32'(i + 1); end
    @(negedge clk);
    k_valid = 1'b1; k_data = kern[0]; p_valid = 1'b1; p_data = 32'd7;
    #1;
    vectors++; if (p_ready !== 1'b0 || k_ready !== 1'b1) begin miscompares++; $display("FAIL priority_ready p_ready %b k_ready %b want 0 1", p_ready, k_ready); end
    @(posedge clk);
    #1 k_valid = 1'b0; p_valid = 1'b0;
    vectors++; if (kernel_loaded !== 1'b0 || p_ready !== 1'b0) begin miscompares++; $display("FAIL priority_kernel_taken kernel_loaded %b p_ready %b want 0 0", kernel_loaded, p_ready); end
    load_kernel(1, 0);
    load_patch(0, 1'b0);
    exp = model_dot();
    wait_result(n);
    vectors++; if (o_data !== exp || exp !== 32'd90) begin miscompares++; $display("FAIL priority_sum got %0d want %0d (90)", o_data, exp); end
    consume();
    vectors++; if (timed_out) begin miscompares++; $display("FAIL priority_timeout got 1 want 0"); timed_out = 1'b0; end
  endtask

  task automatic test_gaps();
    int n;
    logic [W-1:0] exp;
    load_patch(3, 1'b0);
    exp = model_dot();
    wait_result(n);
    vectors++; if (n !== 10) begin miscompares++; $display("FAIL gaps_latency got %0d edges want 10", n); end
    vectors++; if (o_data !== exp || exp !== 32'd90) begin miscompares++; $display("FAIL gaps_sum got %0d want %0d (90)", o_data, exp); end
    consume();
    vectors++; if (timed_out) begin miscompares++; $display("FAIL gaps_timeout got 1 want 0"); timed_out = 1'b0; end
  endtask

  task automatic test_random();
    int n;
    logic [W-1:0] exp;
    for (int it = 0; it < 8; it++) begin
      if (it % 3 == 0) begin
        for (int i = 0; i < S; i++) kern[i] = (it == 3) ? 32'($urandom_range(0, 15)) : $urandom;
        load_kernel(0, 2);
      end
      for (int i = 0; i < S; i++) pat[i] = $urandom;
      load_patch(2, 1'b1);
      exp = model_dot();
      wait_result(n);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      vectors++; if (o_valid !== 1'b1 || o_data !== exp) begin miscompares++; $display("FAIL random_%0d o_valid %b o_data %h want 1 %h", it, o_valid, o_data, exp); end
      consume();
    end
    vectors++; if (timed_out) begin miscompares++; $display("FAIL random_timeout got 1 want 0"); timed_out = 1'b0; end
  endtask

  task automatic test_reset_in_sum();
    int n;
    logic [W-1:0] exp;
    for (int i = 0; i < S; i++) pat[i] = $urandom;
    load_patch(0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    vectors++; if (busy !== 1'b1 || o_valid !== 1'b0) begin miscompares++; $display("FAIL rst_sum_pre busy %b o_valid %b want 1 0", busy, o_valid); end
    rst = 1'b1;
    p_valid = 1'b1; p_data = 32'd9;
    #1;
    vectors++; if (o_valid !== 1'b0 || kernel_loaded !== 1'b0 || k_ready !== 1'b1 || p_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL rst_sum_abort o_valid %b kernel_loaded %b k_ready %b p_ready %b busy %b want 0 0 1 0 0", o_valid, kernel_loaded, k_ready, p_ready, busy);
    end
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      #1;
      vectors++; if (p_ready !== 1'b0 || o_valid !== 1'b0) begin miscompares++; $display("FAIL rst_sum_refuse cycle %0d p_ready %b o_valid %b want 0 0", c, p_ready, o_valid); end
    end
    p_valid = 1'b0;
    for (int i = 0; i < S; i++) begin kern[i] = $urandom; pat[i] = $urandom; end
    load_kernel(0, 0);
    load_patch(0, 1'b0);
    exp = model_dot();
    wait_result(n);
    vectors++; if (o_data !== exp || n !== 10) begin miscompares++; $display("FAIL rst_sum_recover o_data %h latency %0d want %h 10", o_data, n, exp); end
    consume();
    vectors++; if (timed_out) begin miscompares++; $display("FAIL rst_sum_timeout got 1 want 0"); timed_out = 1'b0; end
  endtask

  initial begin
    test_reset();
    test_no_kernel();
    test_basic();
    test_wrap();
    test_backpressure();
    test_kernel_priority();
    test_gaps();
    test_random();
    test_reset_in_sum();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
